// File: rtl/cf_sram_ctrl.sv
// Valid/ready front-end for the CF_SRAM_1024x32 macro: drives EN/R_WB/AD/BEN/DI,
// registers read data into a held response, and optionally zero-fills the array after reset.
module cf_sram_ctrl #(
  parameter int DEPTH         = 1024,
  parameter int AW            = 10,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic          CLKin,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          init_done,
  output logic          sram_en,
  output logic          sram_r_wb,
  output logic [AW-1:0] sram_ad,
  output logic [31:0]   sram_ben,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do,
  output logic [6:0]    sram_tie
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam state_t        RST_STATE = INIT_ON_RESET ? S_INIT : S_IDLE;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_init_done;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic [AW-1:0] r_ad;
  logic [31:0]   r_ben;
  logic [31:0]   r_di;

  logic          w_accept;
  logic [31:0]   w_be_mask;
  logic          w_en;
  logic          w_r_wb;
  logic [AW-1:0] w_ad;
  logic [31:0]   w_ben;
  logic [31:0]   w_di;

  // Gating with rst makes EN and ready fall the instant reset asserts, even though
  // the reset state (INIT) would otherwise drive an enable.
  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_be_mask[8*i +: 8] = {8{req_be[i]}};
    end
  end

  // Address/data/byte-enable pins hold their last driven value when no access issues.
  always_comb begin
    w_en   = 1'b0;
    w_r_wb = 1'b0;
    w_ad   = r_ad;
    w_ben  = r_ben;
    w_di   = r_di;
    if (!rst) begin
      if (r_state == S_INIT) begin
        w_en  = 1'b1;
        w_ad  = r_cnt;
        w_ben = '1;
        w_di  = '0;
      end else if (w_accept) begin
        w_ad = req_addr;
        if (req_we) begin
          w_en  = |req_be;
          w_ben = w_be_mask;
          w_di  = req_wdata;
        end else begin
          w_en   = 1'b1;
          w_r_wb = 1'b1;
          w_ben  = '0;
        end
      end
    end
  end

  always_ff @(posedge CLKin or posedge rst) begin
    if (rst) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_init_done <= ~INIT_ON_RESET;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_ad        <= '0;
      r_ben       <= '0;
      r_di        <= '0;
    end else begin
      r_ad  <= w_ad;
      r_ben <= w_ben;
      r_di  <= w_di;
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_cnt       <= '0;
            r_init_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_accept && !req_we) begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_rsp_rdata <= sram_do;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= RST_STATE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;
  assign sram_en   = w_en;
  assign sram_r_wb = w_r_wb;
  assign sram_ad   = w_ad;
  assign sram_ben  = w_ben;
  assign sram_di   = w_di;
  assign sram_tie  = '0;

endmodule

// File: tb/tb_cf_sram_ctrl.sv
// Directed bench for cf_sram_ctrl with a behavioural model of the 1024x32 macro.
module tb_cf_sram_ctrl;

  logic        CLKin = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        sram_en;
  logic        sram_r_wb;
  logic [9:0]  sram_ad;
  logic [31:0] sram_ben;
  logic [31:0] sram_di;
  logic [31:0] sram_do;
  logic [6:0]  sram_tie;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];

  always #5 CLKin = ~CLKin;

  cf_sram_ctrl #(.DEPTH(1024), .AW(10), .INIT_ON_RESET(1'b1)) dut (
    .CLKin(CLKin), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_en(sram_en), .sram_r_wb(sram_r_wb), .sram_ad(sram_ad),
    .sram_ben(sram_ben), .sram_di(sram_di), .sram_do(sram_do),
    .sram_tie(sram_tie)
  );

  // Macro model: synchronous read into DO, bit-masked write.
  always @(posedge CLKin) begin
    if (sram_en) begin
      if (sram_r_wb) sram_do <= mem[sram_ad];
      else mem[sram_ad] <= (mem[sram_ad] & ~sram_ben) | (sram_di & sram_ben);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKin);
    #1;
  endtask

  task automatic fill_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("fill", {sram_en, sram_r_wb, sram_ad, sram_ben, sram_di, req_ready, init_done},
          {1'b1, 1'b0, 10'(i), 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0});
      tick();
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] exp_ben, input logic exp_en);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    #1;
    chk("wr_issue", {sram_en, sram_r_wb, sram_ad, sram_ben, sram_di, req_ready},
        {exp_en, 1'b0, a, exp_ben, d, 1'b1});
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    chk("wr_hold", {sram_en, sram_ad, sram_ben, sram_di, req_ready},
        {1'b0, a, exp_ben, d, 1'b1});
  endtask

  task automatic do_read(input logic [9:0] a, input logic [31:0] exp, input int hold);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    chk("rd_issue", {sram_en, sram_r_wb, sram_ad, sram_ben, req_ready},
        {1'b1, 1'b1, a, 32'h0, 1'b1});
    tick();
    req_valid = 1'b0;
    #1;
    chk("rd_wait", {sram_en, req_ready, rsp_valid}, 3'b000);
    tick();
    chk("rd_data", {rsp_valid, rsp_rdata, req_ready}, {1'b1, exp, 1'b0});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rd_stall", {rsp_valid, rsp_rdata, req_ready, sram_en}, {1'b1, exp, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rd_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    #2;
    chk("reset", {req_ready, rsp_valid, rsp_rdata, init_done, sram_en, sram_tie},
        {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'h0});
    tick(); tick();
    rst = 1'b0;
    #1;
    fill_check(1024);
    chk("fill_end", {init_done, req_ready, sram_en}, 3'b110);

    do_read(10'd7, 32'h0, 0);
    do_write(10'd5, 32'hDEAD_BEEF, 4'hF, 32'hFFFF_FFFF, 1'b1);
    do_read(10'd5, 32'hDEAD_BEEF, 0);
    do_write(10'd5, 32'h1122_3344, 4'b0101, 32'h00FF_00FF, 1'b1);
    do_read(10'd5, 32'hDE22_BE44, 10);
    do_write(10'd5, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    do_read(10'd5, 32'hDE22_BE44, 0);

    // Back-to-back writes with valid held high.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd1023; req_wdata = 32'hA5A5_0001; req_be = 4'hF;
    #1;
    chk("b2b_w0", {sram_en, sram_ad, sram_di, req_ready}, {1'b1, 10'd1023, 32'hA5A5_0001, 1'b1});
    tick();
    req_addr = 10'd0; req_wdata = 32'h5A5A_0002; req_be = 4'b1000;
    #1;
    chk("b2b_w1", {sram_en, sram_ad, sram_ben, sram_di, req_ready},
        {1'b1, 10'd0, 32'hFF00_0000, 32'h5A5A_0002, 1'b1});
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    do_read(10'd1023, 32'hA5A5_0001, 0);
    do_read(10'd0, 32'h5A00_0000, 0);

    // Leave a non-zero response register, then reset in RD_WAIT.
    do_read(10'd5, 32'hDE22_BE44, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    tick();
    req_valid = 1'b0;
    #1;
    chk("pre_rst_wait", {req_ready, rsp_valid, rsp_rdata}, {1'b0, 1'b0, 32'hDE22_BE44});
    rst = 1'b1;
    #1;
    chk("rst_rdwait", {sram_en, rsp_valid, rsp_rdata, req_ready, init_done}, 35'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    fill_check(500);
    rst = 1'b1;
    #1;
    chk("rst_fill", {sram_en, sram_ad, init_done, req_ready}, 13'h0);
    tick();
    rst = 1'b0;
    #1;
    fill_check(1024);
    chk("refill_end", {init_done, req_ready}, 2'b11);
    do_read(10'd5, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cf_sram_ctrl.md
Name: cf_sram_ctrl

Overview:
Request/response front-end that sits directly upstream of the CF_SRAM_1024x32 macro and drives all of its pins. It converts a valid/ready word-access interface with byte enables into the macro's EN / R_WB / AD / BEN / DI protocol. It captures read data into a held response register with backpressure, and can zero-fill the whole array after reset. Test and scan pins of the macro are tied inactive.

Parameters:
DEPTH, 1024, number of words; the initialisation counter runs 0..DEPTH-1.
AW, 10, address width; DEPTH <= 2**AW.
INIT_ON_RESET, 1, 1 = zero-fill the array after reset before accepting requests; 0 = skip the fill.

Ports:
CLKin  in  1  single clock; also the clock fed to the macro.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller accepts the request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  AW  word address.
req_wdata  in  32  write data.
req_be  in  4  byte enables; bit i covers data bits [8i+7:8i].
rsp_valid  out  1  read data valid.
rsp_ready  in  1  consumer takes the read data.
rsp_rdata  out  32  read data.
init_done  out  1  high once the controller is in service.
sram_en  out  1  to EN.
sram_r_wb  out  1  to R_WB (1 = read).
sram_ad  out  AW  to AD.
sram_ben  out  32  to BEN.
sram_di  out  32  to DI.
sram_do  in  32  from DO.
sram_tie  out  7  {WLBI,SM,TM,ScanInDR,ScanInDL,ScanInCC,vpwrpc}; constant 0.

Behaviour:
- Clock and reset: one clock, CLKin. rst is asynchronous, active-high, and resets every register immediately.
- States: INIT, IDLE, RD_WAIT, RESP. The rst value is INIT if INIT_ON_RESET=1, otherwise IDLE.
- Output reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - init_done = ~INIT_ON_RESET.
  - init counter = 0.
  - sram_en=0 (sram_* outputs are combinational from state, so EN drops the moment rst asserts).
- INIT, every cycle:
  - Drive sram_en=1, sram_r_wb=0, sram_ad=cnt, sram_ben=all 1s, sram_di=0.
  - cnt increments.
  - When cnt==DEPTH-1 this cycle, go to IDLE with init_done=1 on the next edge. The fill takes exactly DEPTH cycles.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - Accept means req_valid & req_ready. On accept, the sram_* outputs are driven combinationally from the request in the same cycle, so the macro samples the request at that edge (call it edge N).
- Write accept:
  - sram_en = |req_be, sram_r_wb=0, sram_di=req_wdata.
  - sram_ben[8i+7:8i] = {8{req_be[i]}}.
  - No response is generated and the state stays IDLE, so back-to-back writes run one per cycle.
  - be==0 is accepted as a no-op: no EN pulse.
- Read accept:
  - sram_en=1, sram_r_wb=1, sram_ben=0.
  - Go to RD_WAIT.
- RD_WAIT:
  - sram_en=0, req_ready=0.
  - At edge N+1, rsp_rdata <= sram_do, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata is held stable until rsp_ready.
  - req_ready=0.
  - On rsp_ready, rsp_valid drops at the next edge and the state returns to IDLE. The next request can be accepted in the cycle after the handshake.
- Read latency: rsp_valid is high in the cycle after edge N+1. Minimum read-to-read spacing is 3 cycles.
- Whenever no access is being issued, sram_ad / sram_di / sram_ben hold the last driven values and sram_en=0.
- req_addr >= DEPTH is passed through unchanged; there is no range check.
- If rst asserts mid-read or mid-fill, the operation is aborted, rsp_valid=0, and the fill restarts from 0.

Test Plan:
- Reset with INIT_ON_RESET=1 -> init_done rises after exactly 1024 cycles; 1024 write pulses with DI=0, BEN=0xFFFFFFFF, AD 0..1023; req_ready=0 during the fill.
- Write addr 5, data 0xDEADBEEF, be=4'hF, then read addr 5 -> sram_en pulses once per access; rsp_valid 2 cycles after the read accept; rsp_rdata=0xDEADBEEF.
- Write addr 5, data 0x11223344, be=4'b0101, then read addr 5 -> rsp_rdata=0xDE22BE44; sram_ben=0x00FF00FF during the write.
- Read with rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; after rsp_ready=1, IDLE and req_ready=1 the following cycle.
- Write with be=0 -> accepted, no EN pulse; a subsequent read returns the old data.
- Assert rst during RD_WAIT, and again at fill count 500 -> rsp_valid=0 and sram_en=0 immediately; the fill restarts at AD=0.
